// File: rtl/adder_pkg.sv
// Shared definitions for the 3-bit ripple-carry adder.
//   ADDER_WIDTH : operand width the block is built and verified at
//   operand_t   : operand type
//   ref_sum()   : behavioural reference {cout,s} = a + b + cin
package adder_pkg;

    localparam int ADDER_WIDTH = 3;

    typedef logic [ADDER_WIDTH-1:0] operand_t;

    function automatic logic [ADDER_WIDTH:0] ref_sum(
        input operand_t a,
        input operand_t b,
        input logic     cin
    );
        return {1'b0, a} + {1'b0, b} + {{ADDER_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_3bit_full_adder.sv
// One-bit full adder cell, the leaf of the ripple-carry chain.
//   a, b : operand bits
//   cin  : carry in from the next-lower bit
//   s    : sum bit
//   cout : carry out to the next-higher bit
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_3bit.sv
// 3-bit ripple-carry adder with carry-in, carry-out and signed overflow,
// plus a one-cycle registered copy of all results.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (clears registered outputs only)
//   a, b   : unsigned operands
//   cin    : carry in
//   s      : combinational sum bits
//   cout   : combinational carry out
//   ovf    : combinational signed overflow (carry into MSB ^ carry out of MSB)
//   s_q, cout_q, ovf_q : registered s/cout/ovf, captured every rising clk
module adder_3bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             ovf_q
);

    // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
    logic [WIDTH:0] c;

    assign c[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (c[i]),
                .s    (s[i]),
                .cout (c[i+1])
            );
        end
    endgenerate

    assign cout = c[WIDTH];
    assign ovf  = c[WIDTH-1] ^ c[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s;
            cout_q <= cout;
            ovf_q  <= ovf;
        end
    end

endmodule

// File: tb/tb_adder_3bit.sv
module tb_adder_3bit;

    logic       clk;
    logic       rst_n;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic [2:0] s;
    logic       cout;
    logic       ovf;
    logic [2:0] s_q;
    logic       cout_q;
    logic       ovf_q;

    int checks;
    int errors;

    // Scoreboard entries are {ovf, cout, s[2:0]}.
    logic [4:0] sb_q[$];

    adder_3bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .s      (s),
        .cout   (cout),
        .ovf    (ovf),
        .s_q    (s_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent model: arithmetic sum plus signed-overflow rule
    // (operands share a sign and the result sign differs).
    function automatic logic [4:0] model(input logic [2:0] ma, input logic [2:0] mb,
                                         input logic mc);
        int       tot;
        logic [3:0] t;
        logic       v;
        tot = int'(ma) + int'(mb) + int'(mc);
        t   = tot[3:0];
        v   = (ma[2] == mb[2]) && (t[2] != ma[2]);
        return {v, t};
    endfunction

    task automatic drive(input logic [2:0] na, input logic [2:0] nb, input logic nc);
        a   = na;
        b   = nb;
        cin = nc;
        sb_q.push_back(model(na, nb, nc));
    endtask

    task automatic test_reset();
        logic [4:0] e;
        rst_n = 1'b0;
        drive(3'd5, 3'd2, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({ovf, cout, s} !== e) begin
            errors++;
            $display("FAIL reset_comb: got %b expected %b", {ovf, cout, s}, e);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ovf_q, cout_q, s_q} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 00000", {ovf_q, cout_q, s_q});
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(model(a, b, cin));
        #1;
        checks++;
        if (s_q !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_no_edge: got %b expected 000", s_q);
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({ovf_q, cout_q, s_q} !== e || s_q !== 3'b111) begin
            errors++;
            $display("FAIL reset_first_capture: got %b expected %b", {ovf_q, cout_q, s_q}, e);
        end
    endtask

    task automatic test_exhaustive();
        logic [4:0] e;
        for (int i = 0; i < 128; i++) begin
            drive(i[5:3], i[2:0], i[6]);
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({ovf, cout, s} !== e) begin
                errors++;
                $display("FAIL exhaustive i=%0d: got %b expected %b", i, {ovf, cout, s}, e);
            end
        end
    endtask

    task automatic test_boundary();
        logic [4:0] e;
        logic [3:0] req [3];
        logic [6:0] vec [3];
        vec[0] = {3'd0, 3'd0, 1'b0}; req[0] = 4'b0000;
        vec[1] = {3'd7, 3'd7, 1'b1}; req[1] = 4'b1111;
        vec[2] = {3'd7, 3'd0, 1'b1}; req[2] = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            drive(vec[k][6:4], vec[k][3:1], vec[k][0]);
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({cout, s} !== req[k] || {ovf, cout, s} !== e) begin
                errors++;
                $display("FAIL boundary%0d: got %b expected %b", k, {ovf, cout, s}, {e[4], req[k]});
            end
        end
    endtask

    task automatic test_overflow();
        logic [4:0] e;
        drive(3'b011, 3'b001, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (s !== 3'b100 || ovf !== 1'b1 || {ovf, cout, s} !== e) begin
            errors++;
            $display("FAIL ovf_pos: got %b expected 10100", {ovf, cout, s});
        end
        drive(3'b100, 3'b100, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({ovf, cout, s} !== 5'b11000 || {ovf, cout, s} !== e) begin
            errors++;
            $display("FAIL ovf_neg: got %b expected 11000", {ovf, cout, s});
        end
        drive(3'b111, 3'b001, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (ovf !== 1'b0 || {ovf, cout, s} !== e) begin
            errors++;
            $display("FAIL ovf_none: got %b expected %b", {ovf, cout, s}, e);
        end
    endtask

    task automatic test_latency();
        logic [4:0] e;
        logic [4:0] prev;
        @(negedge clk);
        drive(3'd5, 3'd2, 1'b0);
        @(posedge clk);
        #1;
        prev = sb_q.pop_front();
        @(negedge clk);
        drive(3'd1, 3'd1, 1'b0);
        #1;
        checks++;
        if (s !== 3'b010) begin
            errors++;
            $display("FAIL latency_comb: got %b expected 010", s);
        end
        checks++;
        if ({ovf_q, cout_q, s_q} !== prev) begin
            errors++;
            $display("FAIL latency_hold: got %b expected %b", {ovf_q, cout_q, s_q}, prev);
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({ovf_q, cout_q, s_q} !== e || s_q !== 3'b010) begin
            errors++;
            $display("FAIL latency_capture: got %b expected %b", {ovf_q, cout_q, s_q}, e);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] e;
        @(negedge clk);
        drive(3'd3, 3'd3, 1'b0);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (s_q !== 3'b110 || {ovf_q, cout_q, s_q} !== e) begin
            errors++;
            $display("FAIL async_pre: got %b expected %b", {ovf_q, cout_q, s_q}, e);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ovf_q, cout_q, s_q} !== 5'b0) begin
            errors++;
            $display("FAIL async_clear: got %b expected 00000", {ovf_q, cout_q, s_q});
        end
        checks++;
        if ({ovf, cout, s} !== e) begin
            errors++;
            $display("FAIL async_comb: got %b expected %b", {ovf, cout, s}, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            checks++;
            if ({ovf_q, cout_q, s_q} !== e) begin
                errors++;
                $display("FAIL b2b n=%0d: got %b expected %b", n, {ovf_q, cout_q, s_q}, e);
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        test_reset();
        test_exhaustive();
        test_boundary();
        test_overflow();
        test_latency();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
